// File: rtl/if_nco_synth.sv
// Multiphase IF local-oscillator NCO: phase accumulator decoded to a one-hot switch drive,
// glitch-free retune at accumulator wrap. Optional decode dither: define IF_NCO_DITHER_EN.
module if_nco_synth #(
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned FTW_W      = 32,
    parameter int unsigned PHASES     = 4,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned DITHER_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [FTW_W-1:0]          freq_word,
    input  logic                      freq_strobe,
    output logic [PHASES-1:0]         phase_out,
    output logic [$clog2(PHASES)-1:0] phase_idx,
    output logic                      wrap_tick,
    output logic                      busy,
    output logic                      locked
);
    localparam int unsigned IDX_W = $clog2(PHASES);
    localparam int unsigned CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    if (PHASES < 2 || (PHASES & (PHASES - 1)) != 0 || FTW_W > ACC_W ||
        DITHER_W < 1 || DITHER_W > 16) begin : g_param_check
        $error("if_nco_synth: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StPending, StSettle, StLocked} state_e;

    state_e             r_state, w_state_d;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic               w_apply;
    logic [FTW_W-1:0]   r_ftw_active, w_ftw_active_d;
    logic [FTW_W-1:0]   r_ftw_pending, w_ftw_pending_d;
    logic [CNT_W-1:0]   r_settle_cnt, w_settle_cnt_d;
    logic [IDX_W-1:0]   w_dec_idx;
    logic [PHASES-1:0]  r_phase_out;
    logic [IDX_W-1:0]   r_phase_idx;
    logic               r_wrap_tick;
    logic               r_busy;
    logic               r_locked;

    assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(r_ftw_active);
    assign w_carry    = w_sum[ACC_W];
    assign w_acc_next = w_sum[ACC_W-1:0];
    // A zero active word never wraps, so a retune out of a frozen phase must not wait.
    assign w_apply    = (r_state == StPending) && (w_carry || (r_ftw_active == '0));

`ifdef IF_NCO_DITHER_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // Dither perturbs only the decoded phase; the accumulator itself stays exact.
    assign w_dec_idx   = IDX_W'((w_acc_next + ACC_W'(w_lfsr_next[DITHER_W-1:0]))
                                >> (ACC_W - IDX_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    assign w_dec_idx = w_acc_next[ACC_W-1 -: IDX_W];
`endif

    always_comb begin
        w_state_d       = r_state;
        w_ftw_active_d  = r_ftw_active;
        w_ftw_pending_d = r_ftw_pending;
        w_settle_cnt_d  = r_settle_cnt;
        unique case (r_state)
            StIdle, StLocked: begin
                if (freq_strobe) begin
                    w_ftw_pending_d = freq_word;
                    w_state_d       = StPending;
                end
            end
            StPending: begin
                if (w_apply) begin
                    w_ftw_active_d = r_ftw_pending;
                    w_settle_cnt_d = CNT_W'(SETTLE_CYC);
                    w_state_d      = StSettle;
                end
                if (freq_strobe) begin
                    w_ftw_pending_d = freq_word;
                    w_state_d       = StPending;
                end
            end
            StSettle: begin
                if (freq_strobe) begin
                    w_ftw_pending_d = freq_word;
                    w_state_d       = StPending;
                end else if (r_settle_cnt == '0) begin
                    w_state_d = StLocked;
                end else begin
                    w_settle_cnt_d = r_settle_cnt - 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_acc         <= '0;
            r_ftw_active  <= '0;
            r_ftw_pending <= '0;
            r_settle_cnt  <= '0;
            r_phase_out   <= PHASES'(1);
            r_phase_idx   <= '0;
            r_wrap_tick   <= 1'b0;
            r_busy        <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_acc         <= w_acc_next;
            r_ftw_active  <= w_ftw_active_d;
            r_ftw_pending <= w_ftw_pending_d;
            r_settle_cnt  <= w_settle_cnt_d;
            r_phase_out   <= PHASES'(1) << w_dec_idx;
            r_phase_idx   <= w_dec_idx;
            r_wrap_tick   <= w_carry;
            r_busy        <= (w_state_d == StPending) || (w_state_d == StSettle);
            r_locked      <= (w_state_d == StLocked);
        end
    end

    assign phase_out = r_phase_out;
    assign phase_idx = r_phase_idx;
    assign wrap_tick = r_wrap_tick;
    assign busy      = r_busy;
    assign locked    = r_locked;

endmodule

// File: tb/tb_if_nco_synth.sv
// Bench for if_nco_synth: directed literal checks plus random retunes compared every cycle
// against an event-level model (accumulator as plain integer, lock time as an edge number).
module tb_if_nco_synth;
    localparam int ACC_W      = 16;
    localparam int FTW_W      = 16;
    localparam int PHASES     = 4;
    localparam int SETTLE_CYC = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] freq_word = 16'h0;
    logic        freq_strobe = 1'b0;
    logic [3:0]  phase_out;
    logic [1:0]  phase_idx;
    logic        wrap_tick;
    logic        busy;
    logic        locked;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_nco_synth #(
        .ACC_W      (ACC_W),
        .FTW_W      (FTW_W),
        .PHASES     (PHASES),
        .SETTLE_CYC (SETTLE_CYC),
        .DITHER_W   (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .freq_word   (freq_word),
        .freq_strobe (freq_strobe),
        .phase_out   (phase_out),
        .phase_idx   (phase_idx),
        .wrap_tick   (wrap_tick),
        .busy        (busy),
        .locked      (locked)
    );

    // Model state: integer accumulator, pending word flag, edge count, edge at which lock is due.
    int          m_acc = 0, m_active = 0, m_pend = 0, m_edge = 0, m_lock_edge = 0, m_idx = 0;
    bit          m_has_pend = 0, m_applied = 0, m_wrap = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int sum;
        if (!reset_n) begin
            m_acc = 0; m_active = 0; m_pend = 0; m_edge = 0; m_lock_edge = 0; m_idx = 0;
            m_has_pend = 0; m_applied = 0; m_wrap = 0; m_lfsr = 16'hACE1;
        end else begin
            sum = m_acc + m_active;
            m_edge++;
            if (m_has_pend && (sum >= 65536 || m_active == 0)) begin
                m_active    = m_pend;
                m_has_pend  = 0;
                m_applied   = 1;
                m_lock_edge = m_edge + 1 + SETTLE_CYC;
            end
            if (freq_strobe) begin
                m_pend     = int'(freq_word);
                m_has_pend = 1;
            end
            m_wrap = (sum >= 65536);
            m_acc  = sum % 65536;
`ifdef IF_NCO_DITHER_EN
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_idx  = ((m_acc + int'(m_lfsr & 16'hF)) % 65536) / 16384;
`else
            m_idx  = m_acc / 16384;
`endif
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        chk("cyc_phase_idx", 32'(phase_idx), m_idx);
        chk("cyc_phase_out", 32'(phase_out), 32'(1) << m_idx);
        chk("cyc_wrap_tick", 32'(wrap_tick), 32'(m_wrap));
        chk("cyc_busy", 32'(busy), 32'(m_has_pend || (m_applied && m_edge < m_lock_edge)));
        chk("cyc_locked", 32'(locked),
            32'(m_applied && !m_has_pend && m_edge >= m_lock_edge));
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [15:0] w);
        freq_word   = w;
        freq_strobe = 1'b1;
        step();
        freq_strobe = 1'b0;
    endtask

    task automatic lit_idx(input string nm, input int e);
`ifndef IF_NCO_DITHER_EN
        chk(nm, 32'(phase_idx), e);
        chk(nm, 32'(phase_out), 32'(1) << e);
`endif
    endtask

    task automatic wait_locked(input string nm);
        for (int i = 0; i < 300 && !locked; i++) step();
        chk(nm, 32'(locked), 1);
    endtask

    task automatic wait_wrap(input string nm);
        for (int i = 0; i < 40 && !wrap_tick; i++) step();
        chk(nm, 32'(wrap_tick), 1);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int r;
        logic [15:0] last_w;
        // Reset state, then frozen accumulator with no word applied.
        step(3);
        chk("rst_phase_out", 32'(phase_out), 1);
        chk("rst_phase_idx", 32'(phase_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_locked", 32'(locked), 0);
        reset_n = 1'b1;
        step(5);
        lit_idx("idle_frozen", 0);
        chk("idle_busy", 32'(busy), 0);

        // Quadrature at 16'h4000: apply at k+1, lock at k+10.
        strobe(16'h4000);
        chk("c2_busy_k", 32'(busy), 1);
        step(); lit_idx("c2_k1", 0);
        step(); lit_idx("c2_k2", 1);
        step(); lit_idx("c2_k3", 2);
        step(); lit_idx("c2_k4", 3);
        step(); lit_idx("c2_k5", 0);
        chk("c2_wrap_k5", 32'(wrap_tick), 1);
        step(); lit_idx("c2_k6", 1);
        chk("c2_wrap_k6", 32'(wrap_tick), 0);
        step(3);
        chk("c2_locked_k9", 32'(locked), 0);
        step();
        chk("c2_locked_k10", 32'(locked), 1);
        chk("c2_busy_k10", 32'(busy), 0);

        // Retune 0x1000 -> 0x3000 waits for the wrap and continues phase smoothly.
        reset_pulse();
        strobe(16'h1000);
        wait_locked("c3_lock1");
        for (int i = 0; i < 40 && m_acc != 16'h5000; i++) step();
        lit_idx("c3_at5000", 1);
        strobe(16'h3000);
        lit_idx("c3_6000", 1);
        chk("c3_busy", 32'(busy), 1);
        wait_wrap("c3_wrap");
        lit_idx("c3_0000", 0);
        chk("c3_busy_wrap", 32'(busy), 1);
        step(); lit_idx("c3_3000", 0);
        step(); lit_idx("c3_6000b", 1);
        step(); lit_idx("c3_9000", 2);
        step(); lit_idx("c3_c000", 3);
        wait_locked("c3_lock2");

        // Two strobes while pending (last wins), then a strobe during settle.
        wait_wrap("c4_sync");
        strobe(16'h0800);
        strobe(16'h2000);
        chk("c4_busy", 32'(busy), 1);
        wait_wrap("c4_apply");
        step(3);
        strobe(16'h0100);
        chk("c4_settle_restrobe_locked", 32'(locked), 0);
        chk("c4_settle_restrobe_busy", 32'(busy), 1);
        wait_locked("c4_lock");

        // Zero word freezes phase; retune out of zero applies next edge.
        strobe(16'h0000);
        wait_locked("c_zero_lock");
        step(5);
        strobe(16'h4000);
        step();
        chk("c_zero_exit_busy", 32'(busy), 1);
        wait_locked("c_zero_relock");

        // Reset mid-settle: outputs drop immediately and nothing is applied later.
        reset_pulse();
        strobe(16'h4000);
        step(3);
        reset_n = 1'b0;
        #1;
        chk("c5_phase_out", 32'(phase_out), 1);
        chk("c5_phase_idx", 32'(phase_idx), 0);
        chk("c5_busy", 32'(busy), 0);
        chk("c5_locked", 32'(locked), 0);
        chk("c5_wrap", 32'(wrap_tick), 0);
        step();
        reset_n = 1'b1;
        step(20);
        lit_idx("c5_after", 0);
        chk("c5_after_busy", 32'(busy), 0);

        // Random retunes, including zero and repeated words, with rare resets.
        last_w = 16'h1234;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(999) == 0) begin
                reset_pulse();
            end else if ($urandom_range(15) == 0) begin
                r = $urandom_range(9);
                if (r == 0)      last_w = 16'h0000;
                else if (r != 1) last_w = 16'($urandom);
                strobe(last_w);
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
